// File: rtl/bch_pkg.sv
// ---------------------------------------------------------------------------
// bch_pkg
// Shared definitions for the multi-code BCH decoder:
//   - code_t      : runtime code selector values
//   - M_OF_CODE   : field symbol width m for a code
//   - T_OF_CODE   : correction capability t for a code
//   - POLY_OF_CODE: primitive field polynomial for a code
//   - state_t     : key-equation solver FSM states
// Default widths used by the solver parameters are also kept here.
// ---------------------------------------------------------------------------
package bch_pkg;

   localparam int BCH_M_MAX = 10;
   localparam int BCH_T_MAX = 4;
   localparam int BCH_L_W   = 4;

   typedef enum logic [1:0] {
      CODE_NONE = 2'd0,
      CODE_63   = 2'd1,
      CODE_255  = 2'd2,
      CODE_1023 = 2'd3
   } code_t;

   localparam logic [BCH_M_MAX:0] POLY_M6  = 11'h043;
   localparam logic [BCH_M_MAX:0] POLY_M8  = 11'h11D;
   localparam logic [BCH_M_MAX:0] POLY_M10 = 11'h409;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DISC = 3'd1,
      UPD  = 3'd2,
      CHK  = 3'd3,
      DONE = 3'd4
   } state_t;

   function automatic logic [3:0] M_OF_CODE(input logic [1:0] code);
      case (code)
         CODE_63:   return 4'd6;
         CODE_255:  return 4'd8;
         CODE_1023: return 4'd10;
         default:   return 4'd0;
      endcase
   endfunction

   function automatic logic [2:0] T_OF_CODE(input logic [1:0] code);
      case (code)
         CODE_63:   return 3'd2;
         CODE_255:  return 3'd2;
         CODE_1023: return 3'd4;
         default:   return 3'd0;
      endcase
   endfunction

   function automatic logic [BCH_M_MAX:0] POLY_OF_CODE(input logic [1:0] code);
      case (code)
         CODE_63:   return POLY_M6;
         CODE_255:  return POLY_M8;
         CODE_1023: return POLY_M10;
         default:   return '0;
      endcase
   endfunction

endpackage

// File: rtl/gf_mul_var.sv
// ---------------------------------------------------------------------------
// gf_mul_var
// Combinational GF(2^m) multiplier with the field chosen at runtime.
// Shift-and-reduce in polynomial basis; m may be anything up to M_MAX.
// Ports:
//   a, b  : operands, bits at and above m are ignored / expected zero
//   poly  : field polynomial including the x^m term
//   m     : field symbol width
//   p     : product a*b mod poly, masked to m bits
// ---------------------------------------------------------------------------
module gf_mul_var #(
   parameter int M_MAX = 10,
   parameter int MW    = $clog2(M_MAX + 1)
) (
   input  logic [M_MAX-1:0] a,
   input  logic [M_MAX-1:0] b,
   input  logic [M_MAX:0]   poly,
   input  logic [MW-1:0]    m,
   output logic [M_MAX-1:0] p
);

   logic [M_MAX:0]   top;
   logic [M_MAX-1:0] mask;
   logic [M_MAX-1:0] acc;
   logic [M_MAX-1:0] cur;
   logic [M_MAX:0]   nxt;

   always_comb begin
      // top is the one-hot x^m position; for m==M_MAX its low bits are all
      // zero and the subtraction wraps to an all-ones mask.
      top  = (M_MAX+1)'(1) << m;
      mask = top[M_MAX-1:0] - M_MAX'(1);
      acc  = '0;
      cur  = a & mask;
      nxt  = '0;
      for (int i = 0; i < M_MAX; i++) begin
         if (b[i]) acc = acc ^ cur;
         nxt = {cur, 1'b0};
         if ((nxt & top) != '0) nxt = nxt ^ poly;
         cur = nxt[M_MAX-1:0];
      end
      p = acc & mask;
   end

endmodule

// File: rtl/bch_ibm_solver.sv
// ---------------------------------------------------------------------------
// bch_ibm_solver
// Inversionless Berlekamp-Massey key-equation solver. Takes 2t syndromes and
// produces the error-locator polynomial sigma(x), its BM length L and a fail
// flag for the Chien search. Field and t are chosen per request by 'code'.
// Each iteration spends t+1 cycles on the discrepancy and t+1 cycles on the
// polynomial update, sharing two GF multipliers.
//
// Handshake: 'start' is a one-cycle request honoured only in IDLE (and not
// while rst is high); code/syndromes are captured on that edge. 'busy' is
// high from the next cycle until the result is ready; 'done' then pulses for
// one cycle and sigma/err_len/fail stay valid until the next accepted start.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request pulse
//   code       : 1:(63,51) 2:(255,239) 3:(1023,983) 0:illegal
//   syndromes  : S_j at [(j-1)*M_MAX +: M_MAX], j=1..2*T_MAX
//   busy, done : status
//   fail       : uncorrectable (L>t, deg(sigma)!=L, or illegal code)
//   err_len    : final L
//   sigma      : coeff i at [i*M_MAX +: M_MAX]
//   dbg_state  : current FSM state
// ---------------------------------------------------------------------------
module bch_ibm_solver
   import bch_pkg::*;
#(
   parameter int M_MAX = BCH_M_MAX,
   parameter int T_MAX = BCH_T_MAX,
   parameter int L_W   = BCH_L_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [1:0]                 code,
   input  logic [2*T_MAX*M_MAX-1:0]   syndromes,
   output logic                       busy,
   output logic                       done,
   output logic                       fail,
   output logic [L_W-1:0]             err_len,
   output logic [(T_MAX+1)*M_MAX-1:0] sigma,
   output state_t                     dbg_state
);

   localparam int MW  = $clog2(M_MAX + 1);
   localparam int T_W = $clog2(T_MAX + 1);

   state_t                   state;
   logic [MW-1:0]            m_q;
   logic [T_W-1:0]           t_q;
   logic [M_MAX:0]           poly_q;
   logic                     code_ok;
   logic [2*T_MAX*M_MAX-1:0] syn_q;

   logic [M_MAX-1:0]         sig     [T_MAX+1];
   logic [M_MAX-1:0]         bb      [T_MAX+1];
   logic [M_MAX-1:0]         sig_nxt [T_MAX+1];
   logic [M_MAX-1:0]         gamma;
   logic [M_MAX-1:0]         delta;
   logic signed [L_W:0]      k;
   logic [L_W-1:0]           len;
   logic [L_W-1:0]           r;
   logic [T_W-1:0]           idx;

   int                       j_idx;
   logic [M_MAX-1:0]         syn_sel;
   logic [M_MAX-1:0]         mul0_a, mul0_b, mul1_a, mul1_b;
   logic [M_MAX-1:0]         prod0, prod1, sig_new;
   logic [L_W-1:0]           two_t;
   logic [L_W-1:0]           deg;
   logic                     last_idx;
   logic                     last_r;

   assign dbg_state = state;

   // Multiplier 0: sigma_i * S_{r+1-i} while accumulating the discrepancy,
   // gamma * sigma_i during the update. Multiplier 1: delta * B_{i-1}.
   always_comb begin
      j_idx   = int'(r) + 1 - int'(idx);
      syn_sel = '0;
      if (j_idx >= 1) syn_sel = syn_q[(j_idx-1)*M_MAX +: M_MAX];
      mul0_a  = (state == UPD) ? gamma : syn_sel;
      mul0_b  = sig[idx];
      mul1_a  = delta;
      mul1_b  = (idx == '0) ? '0 : bb[idx - T_W'(1)];
      sig_new = prod0 ^ prod1;
   end

   always_comb begin
      two_t    = L_W'({t_q, 1'b0});
      last_idx = (idx == t_q);
      last_r   = (r == two_t - L_W'(1));
      deg      = '0;
      for (int i = 0; i <= T_MAX; i++)
         if (sig[i] != '0) deg = L_W'(i);
   end

   gf_mul_var #(.M_MAX(M_MAX), .MW(MW)) u_mul0 (
      .a(mul0_a), .b(mul0_b), .poly(poly_q), .m(m_q), .p(prod0)
   );

   gf_mul_var #(.M_MAX(M_MAX), .MW(MW)) u_mul1 (
      .a(mul1_a), .b(mul1_b), .poly(poly_q), .m(m_q), .p(prod1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         m_q     <= '0;
         t_q     <= '0;
         poly_q  <= '0;
         code_ok <= 1'b0;
         syn_q   <= '0;
         for (int i = 0; i <= T_MAX; i++) begin
            sig[i]     <= '0;
            bb[i]      <= '0;
            sig_nxt[i] <= '0;
         end
         gamma   <= '0;
         delta   <= '0;
         k       <= '0;
         len     <= '0;
         r       <= '0;
         idx     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         fail    <= 1'b0;
         err_len <= '0;
         sigma   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  m_q     <= M_OF_CODE(code);
                  t_q     <= T_OF_CODE(code);
                  poly_q  <= POLY_OF_CODE(code);
                  code_ok <= (code != CODE_NONE);
                  syn_q   <= syndromes;
                  for (int i = 0; i <= T_MAX; i++) begin
                     sig[i]     <= (i == 0) ? M_MAX'(1) : '0;
                     bb[i]      <= (i == 0) ? M_MAX'(1) : '0;
                     sig_nxt[i] <= '0;
                  end
                  gamma <= M_MAX'(1);
                  delta <= '0;
                  k     <= '0;
                  len   <= '0;
                  r     <= '0;
                  idx   <= '0;
                  busy  <= 1'b1;
                  state <= (code == CODE_NONE) ? CHK : DISC;
               end
            end

            DISC: begin
               // Terms with no syndrome behind them come in as zero products.
               delta <= (idx == '0) ? prod0 : (delta ^ prod0);
               if (last_idx) begin
                  idx   <= '0;
                  state <= UPD;
               end else begin
                  idx <= idx + T_W'(1);
               end
            end

            UPD: begin
               sig_nxt[idx] <= sig_new;
               if (last_idx) begin
                  // The final coefficient is taken straight from the datapath.
                  for (int i = 0; i <= T_MAX; i++) begin
                     if (i < int'(t_q))       sig[i] <= sig_nxt[i];
                     else if (i == int'(t_q)) sig[i] <= sig_new;
                     else                     sig[i] <= '0;
                  end
                  if ((delta != '0) && !k[L_W]) begin
                     for (int i = 0; i <= T_MAX; i++) bb[i] <= sig[i];
                     gamma <= delta;
                     k     <= ~k;  // two's complement: -k-1
                     len   <= r + L_W'(1) - len;
                  end else begin
                     // B <= x*B, dropping the coefficient that leaves 0..t.
                     bb[0] <= '0;
                     for (int i = 1; i <= T_MAX; i++)
                        bb[i] <= (i <= int'(t_q)) ? bb[i-1] : '0;
                     k <= k + (L_W+1)'(1);
                  end
                  idx <= '0;
                  if (last_r) begin
                     state <= CHK;
                  end else begin
                     r     <= r + L_W'(1);
                     state <= DISC;
                  end
               end else begin
                  idx <= idx + T_W'(1);
               end
            end

            CHK: begin
               for (int i = 0; i <= T_MAX; i++)
                  sigma[i*M_MAX +: M_MAX] <= code_ok ? sig[i] : '0;
               err_len <= len;
               fail    <= !code_ok || (len > L_W'(t_q)) || (deg != len);
               busy    <= 1'b0;
               done    <= 1'b1;
               state   <= DONE;
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
